// File: rtl/otp_trim_pkg.sv
// Shared types, default parameters and checksum helper for the OTP trim loader.
// OTP_TRIM_TIMEOUT_EN adds the read watchdog default.
package otp_trim_pkg;

    localparam int unsigned DEF_NUM_WORDS = 4;
    localparam int unsigned DEF_WORD_W    = 8;
    localparam int unsigned DEF_ADDR_W    = 4;
    localparam int unsigned DEF_BASE_ADDR = 0;
    localparam int unsigned SUM_MAX_W     = 32;
    localparam logic [31:0] DEF_TRIM_DEFAULT = 32'h8080_8080;
`ifdef OTP_TRIM_TIMEOUT_EN
    localparam int unsigned DEF_TIMEOUT_CYC = 8;
`endif

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CHECK,
        DONE,
        ERR
    } trim_state_e;

    // Additive checksum step, wrapped to the low 'width' bits.
    function automatic logic [SUM_MAX_W-1:0] trim_sum(input logic [SUM_MAX_W-1:0] acc,
                                                       input logic [SUM_MAX_W-1:0] word,
                                                       input int unsigned          width);
        logic [SUM_MAX_W-1:0] mask;
        mask = (SUM_MAX_W'(1) << width) - SUM_MAX_W'(1);
        return (acc + word) & mask;
    endfunction

endpackage

// File: rtl/otp_trim_shadow.sv
// Shadow register file holding trim words until the checksum is verified.
module otp_trim_shadow #(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned IDX_W     = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        we_i,
    input  logic [IDX_W-1:0]            idx_i,
    input  logic [WORD_W-1:0]           wdata_i,
    output logic [NUM_WORDS*WORD_W-1:0] rdata_o
);

    logic [NUM_WORDS*WORD_W-1:0] mem_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                if (we_i && (idx_i == IDX_W'(i))) begin
                    mem_q[i*WORD_W +: WORD_W] <= wdata_i;
                end
            end
        end
    end

    assign rdata_o = mem_q;

endmodule

// File: rtl/otp_trim_loader.sv
// Reads trim words plus a checksum from OTP, verifies the sum and drives the trim bus.
// OTP_TRIM_TIMEOUT_EN enables a per-read watchdog that fails the load on a stalled response.
module otp_trim_loader
    import otp_trim_pkg::*;
#(
    parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [NUM_WORDS*WORD_W-1:0] TRIM_DEFAULT = (NUM_WORDS*WORD_W)'(DEF_TRIM_DEFAULT)
`ifdef OTP_TRIM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input  logic                        clk_osc_100k,
    input  logic                        rst_otp,
    input  logic                        otp_rdy,
    output logic                        otp_rd_en,
    output logic [ADDR_W-1:0]           otp_addr,
    input  logic [WORD_W-1:0]           otp_rdata,
    input  logic                        otp_rd_valid,
    output logic [NUM_WORDS*WORD_W-1:0] trim_data,
    output logic                        trim_load_done,
    output logic                        trim_crc_err,
    output logic                        trim_timeout
);

    localparam int unsigned TRIM_W   = NUM_WORDS * WORD_W;
    localparam int unsigned IDX_W    = $clog2(NUM_WORDS + 1);
    localparam int unsigned SH_IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    trim_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
    logic [WORD_W-1:0]  acc_q, acc_d;
    logic [WORD_W-1:0]  csum_q, csum_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [TRIM_W-1:0]  trim_q, trim_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               sh_we_c;
    logic [TRIM_W-1:0]  shadow;
`ifdef OTP_TRIM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tmo_q, tmo_d;
`endif

    otp_trim_shadow #(
        .NUM_WORDS (NUM_WORDS),
        .WORD_W    (WORD_W),
        .IDX_W     (SH_IDX_W)
    ) u_shadow (
        .clk_i   (clk_osc_100k),
        .rst_i   (rst_otp),
        .we_i    (sh_we_c),
        .idx_i   (SH_IDX_W'(idx_q)),
        .wdata_i (otp_rdata),
        .rdata_o (shadow)
    );

    assign idx_nxt = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        csum_d  = csum_q;
        rd_en_d = 1'b0;
        addr_d  = '0;
        trim_d  = trim_q;
        done_d  = done_q;
        err_d   = err_q;
        sh_we_c = 1'b0;
`ifdef OTP_TRIM_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (otp_rdy) begin
                    state_d = REQ;
                    rd_en_d = 1'b1;
                    addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
                end
            end
            REQ: begin
                state_d = WAIT;
`ifdef OTP_TRIM_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (otp_rd_valid) begin
                    if (idx_q < IDX_W'(NUM_WORDS)) begin
                        sh_we_c = 1'b1;
                        acc_d   = WORD_W'(trim_sum(SUM_MAX_W'(acc_q), SUM_MAX_W'(otp_rdata), WORD_W));
                        idx_d   = idx_nxt;
                        state_d = REQ;
                        rd_en_d = 1'b1;
                        addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_nxt);
                    end else begin
                        csum_d  = otp_rdata;
                        state_d = CHECK;
                    end
                end
`ifdef OTP_TRIM_TIMEOUT_EN
                // Counter holds completed WAIT cycles; the last one without data fails the load.
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ERR;
                    trim_d  = TRIM_DEFAULT;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`endif
            end
            CHECK: begin
                done_d = 1'b1;
                if (acc_q == csum_q) begin
                    trim_d  = shadow;
                    state_d = DONE;
                end else begin
                    trim_d  = TRIM_DEFAULT;
                    err_d   = 1'b1;
                    state_d = ERR;
                end
            end
            DONE, ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Losing otp_rdy outranks everything, including a same-cycle read response.
        if ((state_q != IDLE) && !otp_rdy) begin
            state_d = IDLE;
            idx_d   = '0;
            acc_d   = '0;
            rd_en_d = 1'b0;
            addr_d  = '0;
            trim_d  = TRIM_DEFAULT;
            done_d  = 1'b0;
            err_d   = 1'b0;
            sh_we_c = 1'b0;
`ifdef OTP_TRIM_TIMEOUT_EN
            cnt_d   = '0;
            tmo_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_osc_100k) begin
        if (rst_otp) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            csum_q  <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            trim_q  <= TRIM_DEFAULT;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef OTP_TRIM_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            csum_q  <= csum_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            trim_q  <= trim_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef OTP_TRIM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign otp_rd_en      = rd_en_q;
    assign otp_addr       = addr_q;
    assign trim_data      = trim_q;
    assign trim_load_done = done_q;
    assign trim_crc_err   = err_q;
`ifdef OTP_TRIM_TIMEOUT_EN
    assign trim_timeout   = tmo_q;
`else
    assign trim_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_otp_trim_loader.sv
// Scoreboard bench for otp_trim_loader: stimulus queues expectations, a negedge monitor checks them.
module tb_otp_trim_loader;

    localparam logic [31:0] DEF = 32'h8080_8080;

    typedef struct {
        logic [31:0] data;
        logic        done;
        logic        err;
        logic        tmo;
        logic        rd_en;
        logic [3:0]  addr;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_otp;
    logic        otp_rdy;
    logic        otp_rd_en;
    logic [3:0]  otp_addr;
    logic [7:0]  otp_rdata;
    logic        otp_rd_valid;
    logic [31:0] trim_data;
    logic        trim_load_done;
    logic        trim_crc_err;
    logic        trim_timeout;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          stim_timeouts = 0;
    int          mute_addr = -1;
    bit          fin_req = 1'b0;
    bit          fin_ack = 1'b0;
    logic [7:0]  mem [0:15];
    int          addr_q[$];
    exp_t        res_q[$];
    exp_t        snap_q[$];

    otp_trim_loader dut (
        .clk_osc_100k   (clk),
        .rst_otp        (rst_otp),
        .otp_rdy        (otp_rdy),
        .otp_rd_en      (otp_rd_en),
        .otp_addr       (otp_addr),
        .otp_rdata      (otp_rdata),
        .otp_rd_valid   (otp_rd_valid),
        .trim_data      (trim_data),
        .trim_load_done (trim_load_done),
        .trim_crc_err   (trim_crc_err),
        .trim_timeout   (trim_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // OTP responder: read data arrives two edges after the request is seen (3-cycle words).
    initial begin
        logic [3:0] a;
        otp_rd_valid = 1'b0;
        otp_rdata    = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            otp_rd_valid = 1'b0;
            if (otp_rd_en) begin
                a = otp_addr;
                if (int'(a) != mute_addr) begin
                    @(posedge clk);
                    @(posedge clk);
                    #1;
                    otp_rd_valid = 1'b1;
                    otp_rdata    = mem[a];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a request, a completion or a snapshot slot.
    initial begin
        logic done_prev;
        int   ea;
        exp_t r;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_otp) chk("rd_en_during_reset", 32'(otp_rd_en), 32'd0);
            if (otp_rd_en) begin
                if (addr_q.size() == 0) begin
                    chk("unexpected_rd_en_addr", 32'(otp_addr), 32'hFFFF_FFFF);
                end else begin
                    ea = addr_q.pop_front();
                    chk("rd_addr", 32'(otp_addr), 32'(ea));
                end
            end
            if (trim_load_done && !done_prev) begin
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 32'(trim_load_done), 32'd0);
                end else begin
                    r = res_q.pop_front();
                    chk("done_trim_data", trim_data, r.data);
                    chk("done_crc_err", 32'(trim_crc_err), 32'(r.err));
                    chk("done_timeout", 32'(trim_timeout), 32'(r.tmo));
                    if (r.cyc >= 0) chk("done_cycle", 32'(cyc), 32'(r.cyc));
                end
            end
            done_prev = trim_load_done;
            if (snap_q.size() != 0) begin
                r = snap_q.pop_front();
                chk("snap_trim_data", trim_data, r.data);
                chk("snap_done", 32'(trim_load_done), 32'(r.done));
                chk("snap_crc_err", 32'(trim_crc_err), 32'(r.err));
                chk("snap_timeout", 32'(trim_timeout), 32'(r.tmo));
                chk("snap_rd_en", 32'(otp_rd_en), 32'(r.rd_en));
                chk("snap_addr", 32'(otp_addr), 32'(r.addr));
            end
            if (fin_req && !fin_ack) begin
                chk("pending_addr_expectations", 32'(addr_q.size()), 32'd0);
                chk("pending_done_expectations", 32'(res_q.size()), 32'd0);
                chk("wait_budget_expired", 32'(stim_timeouts), 32'd0);
                fin_ack = 1'b1;
            end
        end
    end

    task automatic set_mem(input logic [7:0] w0, w1, w2, w3, cs);
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3; mem[4] = cs;
    endtask

    task automatic push_addrs(input int n);
        for (int i = 0; i < n; i++) addr_q.push_back(i);
    endtask

    task automatic push_res(input logic [31:0] data, input logic err, input logic tmo, input int c);
        exp_t e;
        e.data = data; e.done = 1'b1; e.err = err; e.tmo = tmo;
        e.rd_en = 1'b0; e.addr = 4'd0; e.cyc = c;
        res_q.push_back(e);
    endtask

    task automatic push_snap_reset();
        exp_t e;
        e.data = DEF; e.done = 1'b0; e.err = 1'b0; e.tmo = 1'b0;
        e.rd_en = 1'b0; e.addr = 4'd0; e.cyc = -1;
        snap_q.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!trim_load_done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!trim_load_done) stim_timeouts++;
    endtask

    task automatic wait_req(input logic [3:0] a, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(otp_rd_en && otp_addr == a) && n < budget);
        if (!(otp_rd_en && otp_addr == a)) stim_timeouts++;
    endtask

    // Drop otp_rdy after a load and expect reset-valued outputs one edge later.
    task automatic unload();
        @(posedge clk); #1;
        otp_rdy = 1'b0;
        @(posedge clk); #1;
        push_snap_reset();
        @(posedge clk); #1;
    endtask

    task automatic good_load(input logic [7:0] w0, w1, w2, w3, cs,
                             input logic [31:0] data, input logic err);
        set_mem(w0, w1, w2, w3, cs);
        push_addrs(5);
        push_res(data, err, 1'b0, cyc + 17);
        otp_rdy = 1'b1;
        wait_done(60);
        unload();
    endtask

    initial begin
        int n;
        rst_otp = 1'b1;
        otp_rdy = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst_otp = 1'b0;
        push_snap_reset();
        @(posedge clk); #1;

        good_load(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 32'h4433_2211, 1'b0);
        good_load(8'h11, 8'h22, 8'h33, 8'h44, 8'hAB, DEF, 1'b1);
        good_load(8'hFF, 8'hFF, 8'h01, 8'h01, 8'h00, 32'h0101_FFFF, 1'b0);

        // Abort while waiting on word 2; rdy falls together with its read response.
        set_mem(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
        push_addrs(3);
        otp_rdy = 1'b1;
        wait_req(4'd2, 40);
        repeat (2) @(posedge clk);
        #1;
        otp_rdy = 1'b0;
        @(posedge clk); #1;
        push_snap_reset();
        repeat (2) @(posedge clk);
        #1;
        push_addrs(5);
        push_res(32'h4433_2211, 1'b0, 1'b0, cyc + 17);
        otp_rdy = 1'b1;
        wait_done(60);
        unload();

        // One-cycle reset while waiting on word 3, then a full reload.
        push_addrs(4);
        otp_rdy = 1'b1;
        wait_req(4'd3, 40);
        @(posedge clk); #1;
        rst_otp = 1'b1;
        @(posedge clk); #1;
        rst_otp = 1'b0;
        push_snap_reset();
        push_addrs(5);
        push_res(32'h4433_2211, 1'b0, 1'b0, cyc + 17);
        wait_done(60);
        unload();

        // Responder never answers word 1.
        mute_addr = 1;
        push_addrs(2);
`ifdef OTP_TRIM_TIMEOUT_EN
        push_res(DEF, 1'b1, 1'b1, -1);
        otp_rdy = 1'b1;
        wait_done(40);
`else
        otp_rdy = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        push_snap_reset();
        @(posedge clk); #1;
`endif
        unload();
        mute_addr = -1;

        fin_req = 1'b1;
        n = 0;
        while (!fin_ack && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (!fin_ack) begin
            $display("FAIL monitor_final_check actual=missing required=done");
            bad++;
            total++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
